// File: rtl/spi_rgbled_pkg.sv
// Shared constants and bus types for the SPI-controlled RGB LED driver.
package spi_rgbled_pkg;

    localparam int unsigned REG_W      = 8;
    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned BIT_CNT_W  = 5;

    // Command byte layout
    localparam int unsigned CMD_RD_BIT   = 7;
    localparam int unsigned CMD_ADDR_MSB = 1;
    localparam int unsigned CMD_ADDR_LSB = 0;

    // CTRL register layout
    localparam int unsigned CTRL_EN_BIT = 0;

    // Register map
    localparam logic [ADDR_W-1:0] ADDR_RED   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_GREEN = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_BLUE  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_CTRL  = ADDR_W'(3);

    // PWM period in clk cycles (counter runs 0..PWM_PERIOD-1)
    localparam int unsigned PWM_PERIOD = 255;

    // Register write strobe payload from the SPI slave
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  data;
    } spi_wr_t;

endpackage

// File: rtl/spi_rgbled_spi_slave.sv
// Mode-0 SPI slave: synchronizes the SPI pins into clk, decodes one 16-bit
// command/data frame per CS window and shifts read data out on MISO.
module spi_slave
    import spi_rgbled_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              wr_en_c,
    output spi_wr_t           wr_c,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [REG_W-1:0]  rd_data_i
);

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q;
    logic mosi_meta_q, mosi_sync_q;

    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [REG_W-2:0]     shift_q, shift_d;
    logic                 cmd_rd_q, cmd_rd_d;
    logic [ADDR_W-1:0]    cmd_addr_q, cmd_addr_d;
    logic                 miso_q, miso_d;
    logic [REG_W-1:0]     miso_sh_q, miso_sh_d;

    logic             sclk_rise, sclk_fall, cs_active;
    logic [REG_W-1:0] rx_byte;

    // Two-flop synchronizers plus one history flop for SCLK edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= spi_sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign cs_active = ~cs_sync_q;
    // Byte completed by the bit currently on MOSI
    assign rx_byte   = {shift_q, mosi_sync_q};

    // Frame decode: bit counting, command latch, write strobe and MISO shifter
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        cmd_rd_d   = cmd_rd_q;
        cmd_addr_d = cmd_addr_q;
        miso_d     = miso_q;
        miso_sh_d  = miso_sh_q;
        wr_en_c    = 1'b0;
        wr_c.addr  = cmd_addr_q;
        wr_c.data  = rx_byte;

        if (!cs_active) begin
            // Idle or aborted frame: restart the count, keep MISO quiet
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            if (sclk_rise && (bit_cnt_q < BIT_CNT_W'(FRAME_BITS))) begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                shift_d   = rx_byte[REG_W-2:0];
                if (bit_cnt_q == BIT_CNT_W'(CMD_BITS - 1)) begin
                    cmd_rd_d   = rx_byte[CMD_RD_BIT];
                    cmd_addr_d = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
                end
                if ((bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) && !cmd_rd_q) begin
                    wr_en_c = 1'b1;
                end
            end
            if (sclk_fall) begin
                if (cmd_rd_q && (bit_cnt_q == BIT_CNT_W'(CMD_BITS))) begin
                    miso_d    = rd_data_i[REG_W-1];
                    miso_sh_d = {rd_data_i[REG_W-2:0], 1'b0};
                end else if (cmd_rd_q && (bit_cnt_q > BIT_CNT_W'(CMD_BITS))
                             && (bit_cnt_q < BIT_CNT_W'(FRAME_BITS))) begin
                    miso_d    = miso_sh_q[REG_W-1];
                    miso_sh_d = {miso_sh_q[REG_W-2:0], 1'b0};
                end else begin
                    miso_d = 1'b0;
                end
            end
        end
    end

    // Frame state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            cmd_rd_q   <= 1'b0;
            cmd_addr_q <= '0;
            miso_q     <= 1'b0;
            miso_sh_q  <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            cmd_rd_q   <= cmd_rd_d;
            cmd_addr_q <= cmd_addr_d;
            miso_q     <= miso_d;
            miso_sh_q  <= miso_sh_d;
        end
    end

    assign spi_miso  = miso_q;
    assign rd_addr_o = cmd_addr_q;

endmodule

// File: rtl/spi_rgbled.sv
// SPI-controlled RGB LED driver: register file, PWM counter, shadow duty
// registers and registered LED comparators behind a mode-0 SPI slave.
module spi_rgbled
    import spi_rgbled_pkg::*;
#(
    parameter int unsigned PWM_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_sclk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic led_r,
    output logic led_g,
    output logic led_b
);

    // Last counter value before wrapping to zero
    localparam logic [PWM_WIDTH-1:0] CNT_LAST = PWM_WIDTH'(PWM_PERIOD - 1);

    logic              wr_en;
    spi_wr_t           wr;
    logic [ADDR_W-1:0] rd_addr;
    logic [REG_W-1:0]  rd_data;

    logic [REG_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic             en_q, en_d;

    logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
    logic [PWM_WIDTH-1:0] sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d;
    logic                 led_r_q, led_r_d, led_g_q, led_g_d, led_b_q, led_b_d;

    spi_slave u_spi (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .wr_en_c   (wr_en),
        .wr_c      (wr),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data)
    );

    // Register file write decode
    always_comb begin
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        en_d    = en_q;
        if (wr_en) begin
            case (wr.addr)
                ADDR_RED:   red_d   = wr.data;
                ADDR_GREEN: green_d = wr.data;
                ADDR_BLUE:  blue_d  = wr.data;
                ADDR_CTRL:  en_d    = wr.data[CTRL_EN_BIT];
                default:    ;
            endcase
        end
    end

    // Read-back mux; unused CTRL bits read as zero
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_RED:   rd_data = red_q;
            ADDR_GREEN: rd_data = green_q;
            ADDR_BLUE:  rd_data = blue_q;
            ADDR_CTRL:  rd_data = {{(REG_W-1){1'b0}}, en_q};
            default:    rd_data = '0;
        endcase
    end

    // PWM counter, period-boundary shadow load and LED compare
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + PWM_WIDTH'(1);
        sh_r_d = sh_r_q;
        sh_g_d = sh_g_q;
        sh_b_d = sh_b_q;
        if (cnt_q == '0) begin
            // Registers as they stood before any same-cycle write
            sh_r_d = PWM_WIDTH'(red_q);
            sh_g_d = PWM_WIDTH'(green_q);
            sh_b_d = PWM_WIDTH'(blue_q);
        end
        led_r_d = en_q & (cnt_q < sh_r_d);
        led_g_d = en_q & (cnt_q < sh_g_d);
        led_b_d = en_q & (cnt_q < sh_b_d);
    end

    // Register file, PWM state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            sh_r_q  <= '0;
            sh_g_q  <= '0;
            sh_b_q  <= '0;
            led_r_q <= 1'b0;
            led_g_q <= 1'b0;
            led_b_q <= 1'b0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            sh_r_q  <= sh_r_d;
            sh_g_q  <= sh_g_d;
            sh_b_q  <= sh_b_d;
            led_r_q <= led_r_d;
            led_g_q <= led_g_d;
            led_b_q <= led_b_d;
        end
    end

    assign led_r = led_r_q;
    assign led_g = led_g_q;
    assign led_b = led_b_q;

endmodule

// File: tb/tb_spi_rgbled.sv
// Directed bench for spi_rgbled: SPI master tasks, LED duty measurement and
// a queue of expected results checked as the DUT produces them.
module tb_spi_rgbled;

    logic clk = 1'b0;
    logic rst_n;
    logic spi_sclk, spi_cs_n, spi_mosi;
    logic spi_miso, led_r, led_g, led_b;

    int tests = 0;
    int fails = 0;

    int    exp_q[$];
    string tag_q[$];

    spi_rgbled #(.PWM_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .led_r    (led_r),
        .led_g    (led_g),
        .led_b    (led_b)
    );

    always #5 clk = ~clk;

    task automatic sb_push(input string tag, input int val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic sb_check(input int observed);
        string tag;
        int    expv;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_empty: observed %0d with no expected value queued", observed);
        end else begin
            tag  = tag_q.pop_front();
            expv = exp_q.pop_front();
            assert (observed === expv) else begin
                fails++;
                $error("FAIL %s: observed %0d expected %0d", tag, observed, expv);
            end
        end
    endtask

    // Mode-0 master: MOSI set while SCLK low, MISO sampled just before each rise
    task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] data,
                            input int nbits, input bit close,
                            output logic [7:0] rd, output logic [7:0] cmd_miso);
        logic [15:0] frame;
        frame    = {cmd, data};
        rd       = '0;
        cmd_miso = '0;
        spi_cs_n = 1'b0;
        #60;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 16) ? frame[15-i] : 1'b1;
            #50;
            if (i < 8)       cmd_miso[7-i] = spi_miso;
            else if (i < 16) rd[15-i]      = spi_miso;
            spi_sclk = 1'b1;
            #50;
            spi_sclk = 1'b0;
        end
        #60;
        if (close) begin
            spi_cs_n = 1'b1;
            #60;
        end
    endtask

    task automatic spi_write(input logic [1:0] addr, input logic [7:0] data);
        logic [7:0] rd, cm;
        spi_xfer({6'b0, addr}, data, 16, 1'b1, rd, cm);
    endtask

    task automatic spi_read_check(input logic [1:0] addr, input logic [7:0] expv, input string tag);
        logic [7:0] rd, cm;
        sb_push({tag, "_cmd_miso"}, 0);
        sb_push(tag, int'(expv));
        spi_xfer({6'b100000, addr}, 8'h00, 16, 1'b1, rd, cm);
        sb_check(int'(cm));
        sb_check(int'(rd));
    endtask

    task automatic measure(input int n, output int cr, output int cg, output int cb);
        cr = 0; cg = 0; cb = 0;
        repeat (n) begin
            @(negedge clk);
            cr += int'(led_r);
            cg += int'(led_g);
            cb += int'(led_b);
        end
    endtask

    task automatic led_check(input int n, input int er, input int eg, input int eb, input string tag);
        int cr, cg, cb;
        sb_push({tag, "_r"}, er);
        sb_push({tag, "_g"}, eg);
        sb_push({tag, "_b"}, eb);
        measure(n, cr, cg, cb);
        sb_check(cr);
        sb_check(cg);
        sb_check(cb);
    endtask

    initial begin
        logic [7:0] rd, cm;
        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #53;
        sb_push("reset_outputs", 0);
        sb_check(int'({led_r, led_g, led_b, spi_miso}));
        rst_n = 1'b1;
        #100;

        // RED = 0x80, enable: 128 of every 255 cycles on red only
        spi_write(2'd0, 8'h80);
        spi_write(2'd3, 8'h01);
        repeat (260) @(posedge clk);
        led_check(510, 256, 0, 0, "red_half");

        // Reset mid-frame while LEDs run
        spi_xfer(8'h01, 8'hAA, 6, 1'b0, rd, cm);
        rst_n = 1'b0;
        #1;
        sb_push("midframe_reset_outputs", 0);
        sb_check(int'({led_r, led_g, led_b, spi_miso}));
        spi_cs_n = 1'b1;
        #100;
        rst_n = 1'b1;
        #100;
        spi_read_check(2'd0, 8'h00, "rst_red");
        spi_read_check(2'd1, 8'h00, "rst_green");
        spi_read_check(2'd2, 8'h00, "rst_blue");
        spi_read_check(2'd3, 8'h00, "rst_ctrl");
        led_check(300, 0, 0, 0, "rst_leds_off");

        // Restore red, then GREEN = 0xFF / BLUE = 0x00 boundaries over 3 periods
        spi_write(2'd0, 8'h80);
        spi_write(2'd3, 8'h01);
        spi_write(2'd1, 8'hFF);
        spi_write(2'd2, 8'h00);
        repeat (260) @(posedge clk);
        led_check(765, 384, 765, 0, "full_zero");

        // BLUE = 0x5A read back via command 0x82
        spi_write(2'd2, 8'h5A);
        spi_read_check(2'd2, 8'h5A, "rd_blue");

        // Abort after 12 bits of a RED = 0x33 write
        spi_xfer(8'h00, 8'h33, 12, 1'b1, rd, cm);
        spi_read_check(2'd0, 8'h80, "abort_red");

        // Extra bits after 16 are ignored
        spi_xfer(8'h01, 8'h11, 20, 1'b1, rd, cm);
        spi_read_check(2'd1, 8'h11, "extra_bits_green");

        // CTRL only keeps bit 0
        spi_write(2'd3, 8'hFF);
        spi_read_check(2'd3, 8'h01, "ctrl_mask");

        // Disable while running: LEDs drop right after the commit
        spi_write(2'd3, 8'h00);
        #1;
        sb_push("disable_immediate", 0);
        sb_check(int'({led_r, led_g, led_b}));
        led_check(300, 0, 0, 0, "disabled");

        // Re-enable: stored duties resume
        spi_write(2'd3, 8'h01);
        repeat (260) @(posedge clk);
        led_check(255, 128, 17, 90, "resume");

        tests++;
        assert (exp_q.size() === 0) else begin
            fails++;
            $error("FAIL sb_leftover: observed %0d expected %0d", exp_q.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
